// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared CPU pipeline definitions: stage-state encoding,
//               default bubble (NOP) payload and performance-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam logic [31:0] c_bubble_default = 32'h0000_0000;
    localparam int          c_cnt_w          = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge CLK) begin
        if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline latch for PC + payload with optional
//               two-entry skid buffer, flush-to-bubble and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                PC_W   = 32,
    parameter int                DATA_W = 32,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(c_bubble_default),
    parameter int                CNT_W  = c_cnt_w
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic [PC_W-1:0]   r_m_pc;
    logic [PC_W-1:0]   r_s_pc;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_s_data;
    logic              w_m_valid;
    logic              w_s_valid;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_load_m_in;
    logic              w_load_m_s;
    logic              w_load_s;

    assign w_m_valid  = (r_state != ST_EMPTY);
    assign w_s_valid  = (r_state == ST_TWO);
    assign w_xfer_in  = in_valid & in_ready;
    assign w_xfer_out = w_m_valid & out_ready;

    // Outputs come only from registers; invalid stage shows a clean bubble.
    assign out_valid = w_m_valid;
    assign out_pc    = w_m_valid ? r_m_pc : '0;
    assign out_data  = w_m_valid ? r_m_data : BUBBLE;

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end

            assign in_ready = r_in_ready | flush;
        end else begin : g_no_skid
            assign in_ready = out_ready | ~w_m_valid | flush;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer_in) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_xfer_in && w_xfer_out) begin
                    w_load_m_in = 1'b1;
                end else if (w_xfer_out) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_xfer_in) begin
                    w_state_nxt = ST_TWO;
                    w_load_s    = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_xfer_out) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_s  = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush discards everything, including a beat accepted this cycle.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_m_in = 1'b0;
            w_load_m_s  = 1'b0;
            w_load_s    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_m_pc   <= '0;
            r_m_data <= BUBBLE;
            r_s_pc   <= '0;
            r_s_data <= BUBBLE;
        end else begin
            if (w_load_m_in) begin
                r_m_pc   <= in_pc;
                r_m_data <= in_data;
            end else if (w_load_m_s) begin
                r_m_pc   <= r_s_pc;
                r_m_data <= r_s_data;
            end
            if (w_load_s) begin
                r_s_pc   <= in_pc;
                r_s_data <= in_data;
            end
        end
    end

    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = w_m_valid & ~out_ready & ~flush;
    assign w_flush_inc = flush & (w_m_valid | w_s_valid);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .clr   (RESET),
        .inc   (w_stall_inc),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clr   (RESET),
        .inc   (w_flush_inc),
        .value (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench: directed table plus randomized traffic
//               against a queue-based reference model (SKID=1, SKID=0, CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB_A = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Group A drives two SKID=1 instances (16-bit and 2-bit counters)
    logic        a_rst, a_iv, a_fl, a_ordy;
    logic [31:0] a_pc, a_dat;
    logic        a_ir, a_ov, s_ir, s_ov;
    logic [31:0] a_opc, a_odat, s_opc, s_odat;
    logic [15:0] a_stall, a_fc;
    logic [1:0]  s_stall, s_fc;

    // Group B drives the SKID=0 instance
    logic        b_rst, b_iv, b_fl, b_ordy;
    logic [15:0] b_pc, b_opc;
    logic [7:0]  b_dat, b_odat;
    logic        b_ir, b_ov;
    logic [15:0] b_stall, b_fc;

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .SKID(1), .BUBBLE(BUB_A), .CNT_W(16)) dut_a (
        .CLK(CLK), .RESET(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_pc(a_pc),
        .in_data(a_dat), .flush(a_fl), .out_valid(a_ov), .out_ready(a_ordy),
        .out_pc(a_opc), .out_data(a_odat), .stall_cnt(a_stall), .flush_cnt(a_fc));

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .SKID(1), .BUBBLE(BUB_A), .CNT_W(2)) dut_s (
        .CLK(CLK), .RESET(a_rst), .in_valid(a_iv), .in_ready(s_ir), .in_pc(a_pc),
        .in_data(a_dat), .flush(a_fl), .out_valid(s_ov), .out_ready(a_ordy),
        .out_pc(s_opc), .out_data(s_odat), .stall_cnt(s_stall), .flush_cnt(s_fc));

    pipe_stage_reg #(.PC_W(16), .DATA_W(8), .SKID(0), .CNT_W(16)) dut_b (
        .CLK(CLK), .RESET(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_pc(b_pc),
        .in_data(b_dat), .flush(b_fl), .out_valid(b_ov), .out_ready(b_ordy),
        .out_pc(b_opc), .out_data(b_odat), .stall_cnt(b_stall), .flush_cnt(b_fc));

    // ---------------- reference model: FIFO of in-flight beats ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } beat_a_t;
    typedef struct packed { logic [15:0] pc; logic [7:0]  data; } beat_b_t;

    beat_a_t qa[$];
    beat_b_t qb[$];
    int ma_stall, ma_fc, ms_stall, ms_fc, mb_stall, mb_fc;

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd_a();
        bit      ov, ir;
        beat_a_t b;
        ov = (qa.size() != 0);
        ir = a_fl || (qa.size() < 2);
        if (a_rst) begin
            qa.delete();
            ma_stall = 0; ma_fc = 0; ms_stall = 0; ms_fc = 0;
        end else if (a_fl) begin
            if (ov) begin
                ma_fc = sat_inc(ma_fc, 65535);
                ms_fc = sat_inc(ms_fc, 3);
            end
            qa.delete();
        end else begin
            if (ov && !a_ordy) begin
                ma_stall = sat_inc(ma_stall, 65535);
                ms_stall = sat_inc(ms_stall, 3);
            end
            if (ov && a_ordy) void'(qa.pop_front());
            if (a_iv && ir) begin
                b.pc = a_pc; b.data = a_dat;
                qa.push_back(b);
            end
        end
    endtask

    task automatic upd_b();
        bit      ov, ir;
        beat_b_t b;
        ov = (qb.size() != 0);
        ir = b_fl || b_ordy || !ov;
        if (b_rst) begin
            qb.delete();
            mb_stall = 0; mb_fc = 0;
        end else if (b_fl) begin
            if (ov) mb_fc = sat_inc(mb_fc, 65535);
            qb.delete();
        end else begin
            if (ov && !b_ordy) mb_stall = sat_inc(mb_stall, 65535);
            if (ov && b_ordy) void'(qb.pop_front());
            if (b_iv && ir) begin
                b.pc = b_pc; b.data = b_dat;
                qb.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        upd_a();
        upd_b();
    endtask

    task automatic chk_model_a();
        logic        ov;
        logic [31:0] epc, edat;
        ov = (qa.size() != 0);
        epc = 32'h0; edat = BUB_A;
        if (ov) begin epc = qa[0].pc; edat = qa[0].data; end
        chk("a_out_valid", a_ov, ov);
        chk("a_out_pc", a_opc, epc);
        chk("a_out_data", a_odat, edat);
        chk("a_in_ready", a_ir, a_fl || (qa.size() < 2));
        chk("a_stall_cnt", a_stall, ma_stall);
        chk("a_flush_cnt", a_fc, ma_fc);
        chk("s_out_pc", s_opc, epc);
        chk("s_stall_cnt", s_stall, ms_stall);
        chk("s_flush_cnt", s_fc, ms_fc);
    endtask

    task automatic chk_model_b();
        logic        ov;
        logic [15:0] epc;
        logic [7:0]  edat;
        ov = (qb.size() != 0);
        epc = 16'h0; edat = 8'h0;
        if (ov) begin epc = qb[0].pc; edat = qb[0].data; end
        chk("b_out_valid", b_ov, ov);
        chk("b_out_pc", b_opc, epc);
        chk("b_out_data", b_odat, edat);
        chk("b_in_ready", b_ir, b_fl || b_ordy || !ov);
        chk("b_stall_cnt", b_stall, mb_stall);
        chk("b_flush_cnt", b_fc, mb_fc);
    endtask

    task automatic set_a(input logic rst, iv, input logic [31:0] pc, dat, input logic fl, ordy);
        a_rst = rst; a_iv = iv; a_pc = pc; a_dat = dat; a_fl = fl; a_ordy = ordy;
    endtask

    task automatic set_b(input logic rst, iv, input logic [15:0] pc, input logic [7:0] dat,
                         input logic fl, ordy);
        b_rst = rst; b_iv = iv; b_pc = pc; b_dat = dat; b_fl = fl; b_ordy = ordy;
    endtask

    // ---------------- directed table (payload is always pc ^ KEY) ----------------
    typedef struct {
        logic        rst, iv;
        logic [31:0] pc;
        logic        fl, ordy;
        logic        eov;
        logic [31:0] epc;
        logic        eir;
        int          est, efc;
    } vec_t;

    function automatic vec_t mk(input logic rst, iv, input logic [31:0] pc, input logic fl, ordy,
                                input logic eov, input logic [31:0] epc, input logic eir,
                                input int est, efc);
        vec_t v;
        v.rst = rst; v.iv = iv; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.epc = epc; v.eir = eir; v.est = est; v.efc = efc;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [31:0] edat;
        set_a(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        set_b(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        repeat (2) tick();

        // stream 0,4,8,C
        tbl.push_back(mk(0, 1, 32'h000, 0, 1, 0, 32'h000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h004, 0, 1, 1, 32'h000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h008, 0, 1, 1, 32'h004, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h00C, 0, 1, 1, 32'h008, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 1, 32'h00C, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000, 1, 0, 0));
        // backpressure, skid fills, extra beat offered while full
        tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h104, 0, 0, 1, 32'h100, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1F0, 0, 0, 1, 32'h100, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h1F0, 0, 0, 1, 32'h100, 0, 2, 0));
        tbl.push_back(mk(0, 1, 32'h1F0, 0, 0, 1, 32'h100, 0, 3, 0));
        tbl.push_back(mk(0, 1, 32'h1F0, 0, 0, 1, 32'h100, 0, 4, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 1, 32'h100, 0, 5, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 1, 32'h104, 1, 5, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000, 1, 5, 0));
        // flush while TWO with a beat offered
        tbl.push_back(mk(0, 1, 32'h200, 0, 0, 0, 32'h000, 1, 5, 0));
        tbl.push_back(mk(0, 1, 32'h204, 0, 0, 1, 32'h200, 1, 5, 0));
        tbl.push_back(mk(0, 1, 32'h108, 1, 0, 1, 32'h200, 1, 6, 0));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000, 1, 6, 1));
        // flush while EMPTY, with and without a beat offered
        tbl.push_back(mk(0, 0, 32'h000, 1, 1, 0, 32'h000, 1, 6, 1));
        tbl.push_back(mk(0, 1, 32'h300, 1, 1, 0, 32'h000, 1, 6, 1));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000, 1, 6, 1));
        // flush coincident with a downstream transfer
        tbl.push_back(mk(0, 1, 32'h400, 0, 1, 0, 32'h000, 1, 6, 1));
        tbl.push_back(mk(0, 0, 32'h000, 1, 1, 1, 32'h400, 1, 6, 1));
        tbl.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000, 1, 6, 2));
        // reset in the middle of a stall
        tbl.push_back(mk(0, 1, 32'h500, 0, 0, 0, 32'h000, 1, 6, 2));
        tbl.push_back(mk(0, 0, 32'h000, 0, 0, 1, 32'h500, 1, 6, 2));
        tbl.push_back(mk(1, 0, 32'h000, 0, 0, 1, 32'h500, 1, 7, 2));
        tbl.push_back(mk(0, 0, 32'h000, 0, 0, 0, 32'h000, 1, 0, 0));

        foreach (tbl[i]) begin
            @(negedge CLK);
            set_a(tbl[i].rst, tbl[i].iv, tbl[i].pc, tbl[i].pc ^ KEY, tbl[i].fl, tbl[i].ordy);
            #1;
            edat = tbl[i].eov ? (tbl[i].epc ^ KEY) : BUB_A;
            chk($sformatf("t%0d_out_valid", i), a_ov, tbl[i].eov);
            chk($sformatf("t%0d_out_pc", i), a_opc, tbl[i].epc);
            chk($sformatf("t%0d_out_data", i), a_odat, edat);
            chk($sformatf("t%0d_in_ready", i), a_ir, tbl[i].eir);
            chk($sformatf("t%0d_stall_cnt", i), a_stall, tbl[i].est);
            chk($sformatf("t%0d_flush_cnt", i), a_fc, tbl[i].efc);
            chk($sformatf("t%0d_sat_stall", i), s_stall, (tbl[i].est > 3) ? 3 : tbl[i].est);
            chk($sformatf("t%0d_sat_flush", i), s_fc, (tbl[i].efc > 3) ? 3 : tbl[i].efc);
            tick();
        end

        // randomized traffic on the skid instances
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            set_a($urandom_range(63) == 0, $urandom_range(9) < 7, $urandom, $urandom,
                  $urandom_range(15) == 0, $urandom_range(9) < 5);
            #1;
            chk_model_a();
            tick();
        end
        @(negedge CLK);
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // SKID=0: continuous input, out_ready toggling 1,0,1,0...
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            set_b(1'b0, 1'b1, 16'h0010 + 16'(2 * i), 8'(8'h40 + i), 1'b0, (i % 2) == 0);
            #1;
            chk_model_b();
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            set_b(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
            #1;
            chk_model_b();
            tick();
        end

        // randomized traffic on the SKID=0 instance
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            set_b($urandom_range(63) == 0, $urandom_range(9) < 7, 16'($urandom), 8'($urandom),
                  $urandom_range(15) == 0, $urandom_range(9) < 5);
            #1;
            chk_model_b();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed 32-bit fetch/decode pipeline latch.
- Carries a PC plus payload between any two CPU pipeline stages over a valid/ready handshake.
- Supports an optional 2-entry skid buffer for full throughput under backpressure, a flush that turns the stage into a bubble, and saturating stall/flush counters for performance debug.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with different widths.

Parameters:
- PC_W, 32, width of the PC field.
- DATA_W, 32, width of the payload (instruction word or decoded control bundle).
- SKID, 1, 1 = two-entry skid buffer (ready is registered); 0 = single register (ready is combinational from out_ready).
- BUBBLE, 0, payload value driven on out_data whenever the stage holds no valid beat.
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash all held and incoming beats.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  PC_W  held PC.
- out_data  out  DATA_W  held payload.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  out  CNT_W  flush events that killed at least one valid beat, saturating.

Behaviour:
- All state updates on rising CLK. RESET is sampled synchronously and overrides every other input.
- Reset values: out_valid=0, out_pc=0, out_data=BUBBLE, skid entry empty, stall_cnt=0, flush_cnt=0, in_ready=1 from the first cycle after reset.
- Handshake:
  - Upstream transfer when in_valid & in_ready.
  - Downstream transfer when out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- Latency: one cycle from upstream transfer to out_valid, with no combinational path from in_* to out_*.
- SKID=1 state machine (main entry M, skid entry S):
  - EMPTY: in_ready=1. Upstream transfer -> ONE.
  - ONE: in_ready=1.
    - Transfer in and out -> stay ONE, M loads the new beat.
    - Transfer out only -> EMPTY.
    - Transfer in only -> TWO, new beat written to S.
  - TWO: in_ready=0.
    - Transfer out -> ONE, S moves to M.
  - in_ready is driven directly from a register (it is the inverse of S valid).
- SKID=0:
  - in_ready = out_ready | ~out_valid.
  - States are EMPTY and ONE only.
- Ordering: beats leave in the order they arrive; no beat is ever duplicated or dropped except by flush.
- flush:
  - Next cycle M and S are both empty, out_valid=0, out_pc=0, out_data=BUBBLE.
  - in_ready is forced to 1 during the flush cycle so upstream cannot wedge; any beat presented in that cycle is discarded.
  - flush wins over a simultaneous upstream or downstream transfer. A downstream transfer in the same cycle still completes; the consumer must ignore it.
- Bubble: whenever out_valid=0, out_pc=0 and out_data=BUBBLE.
- stall_cnt increments on every cycle with out_valid & ~out_ready & ~flush and holds at 2^CNT_W-1.
- flush_cnt increments on flush when M or S is valid and saturates the same way.
- RESET mid-operation: held beats are discarded, counters cleared, and the stage returns to EMPTY the next cycle.
- Width rules: all paths are straight copies with no truncation. PC_W and DATA_W must each be ≥1.

Decomposition:
- The shared CPU package holds:
  - the stage-state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default BUBBLE/NOP constant;
  - the performance-counter width constant.
- One sub-module, sat_counter (parameter W; inputs inc and clr; output value that saturates at all ones), is instantiated twice for stall_cnt and flush_cnt.
- The datapath and FSM stay in pipe_stage_reg.

Test Plan:
- Reset then stream, SKID=1, out_ready=1, in_pc=0,4,8,… on consecutive cycles -> out_pc=0,4,8,… one cycle later, one beat per cycle, in_ready constantly 1, stall_cnt=0.
- Backpressure: send 0x100/0xAAAA and 0x104/0xBBBB, hold out_ready=0 for 5 cycles -> in_ready=0 after the second beat; out holds 0x100/0xAAAA; stall_cnt=5; on release, 0x100 then 0x104 appear in order.
- Flush in state TWO with in_valid=1 (pc 0x108) -> next cycle out_valid=0, out_data=BUBBLE, out_pc=0, in_ready=1; 0x108 never emerges; flush_cnt=1.
- Flush while EMPTY -> flush_cnt stays 0 and out_valid stays 0.
- SKID=0 build, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready tracks out_ready | ~out_valid in the same cycle; all beats delivered in order.
- Saturation and reset: CNT_W=2, hold out_ready=0 for 6 cycles -> stall_cnt=3 and stays 3; assert RESET for one cycle mid-stall -> next cycle out_valid=0, stall_cnt=0, in_ready=1.
